// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the program loader: FSM state encoding,
// default geometry and the no-op word used to pad unused program entries.
package program_loader_pkg;

    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_INSTR_W = 3;

    // Widest instruction the NOP constant covers; users slice [INSTR_W-1:0].
    localparam int MAX_INSTR_W = 64;
    localparam logic [MAX_INSTR_W-1:0] NOP_WORD = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/program_loader_mem.sv
// Program storage: synchronous write, combinational read, synchronous clear of
// every entry on reset. Held in flops so the whole array can be cleared at once.
module program_mem
    import program_loader_pkg::*;
#(
    parameter  int DEPTH   = DEFAULT_DEPTH,
    parameter  int INSTR_W = DEFAULT_INSTR_W,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]   wr_sel;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_reg[i] <= NOP_WORD[INSTR_W-1:0];
            end else if (wr_sel[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write returns the old word.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Loads a program into program_mem, pads the tail with NOPs and releases the CPU.
// Define PROGRAM_LOADER_PARITY_EN to add in_parity checking and the sticky error.
module program_loader
    import program_loader_pkg::*;
#(
    parameter  int DEPTH   = DEFAULT_DEPTH,
    parameter  int INSTR_W = DEFAULT_INSTR_W,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_last,
`ifdef PROGRAM_LOADER_PARITY_EN
    input  logic               in_parity,
`endif
    output logic               in_ready,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_instr,
    output logic               cpu_reset,
    output logic [AW:0]        load_count,
    output logic               error
);

    state_t             state_reg, state_next;
    logic [AW-1:0]      ptr_reg, ptr_next;
    logic [AW:0]        count_reg, count_next;
    logic               mem_wr_en;
    logic [INSTR_W-1:0] mem_wr_data;
    logic               ptr_at_end;
    logic               parity_bad;

    assign ptr_at_end = (ptr_reg == AW'(DEPTH - 1));

`ifdef PROGRAM_LOADER_PARITY_EN
    logic error_reg;

    // Even parity: in_parity must make the total count of ones even.
    assign parity_bad = ((^in_instr) != in_parity);

    always_ff @(posedge clock) begin
        if (reset) begin
            error_reg <= 1'b0;
        end else if (state_reg == ST_LOAD && in_valid && parity_bad) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    assign parity_bad = 1'b0;
    assign error      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        count_next  = count_reg;
        mem_wr_en   = 1'b0;
        mem_wr_data = in_instr;

        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                    count_next = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (parity_bad) begin
                        state_next = ST_ERR;
                    end else begin
                        mem_wr_en  = 1'b1;
                        count_next = count_reg + (AW+1)'(1);
                        // The pointer parks at the last entry rather than wrapping.
                        if (ptr_at_end) begin
                            state_next = ST_RUN;
                        end else begin
                            ptr_next = ptr_reg + AW'(1);
                            if (in_last) begin
                                state_next = ST_FILL;
                            end
                        end
                    end
                end
            end
            ST_FILL: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = NOP_WORD[INSTR_W-1:0];
                if (ptr_at_end) begin
                    state_next = ST_RUN;
                end else begin
                    ptr_next = ptr_reg + AW'(1);
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                    count_next = '0;
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = (state_reg == ST_LOAD);
    assign cpu_reset  = (state_reg != ST_RUN);
    assign load_count = count_reg;

    program_mem #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (mem_wr_en),
        .wr_addr (ptr_reg),
        .wr_data (mem_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_instr)
    );

endmodule

// File: tb/tb_program_loader.sv
// Scenario-per-task bench for program_loader; expected program words are queued
// as stimulus is driven and popped when the memory is read back in RUN.
module tb_program_loader;

    localparam int DEPTH   = 16;
    localparam int INSTR_W = 3;
    localparam int AW      = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               load_start;
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_last;
    logic               in_ready;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_instr;
    logic               cpu_reset;
    logic [AW:0]        load_count;
    logic               error;
`ifdef PROGRAM_LOADER_PARITY_EN
    logic               in_parity;
`endif

    int checks = 0;
    int passed = 0;
    logic [INSTR_W-1:0] exp_q [$];
    logic [INSTR_W-1:0] e;

    always #5 clock = ~clock;

    program_loader #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_last    (in_last),
`ifdef PROGRAM_LOADER_PARITY_EN
        .in_parity  (in_parity),
`endif
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_instr   (rd_instr),
        .cpu_reset  (cpu_reset),
        .load_count (load_count),
        .error      (error)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_word(input logic v, input logic [INSTR_W-1:0] w, input logic last);
        in_valid = v;
        in_instr = w;
        in_last  = last;
`ifdef PROGRAM_LOADER_PARITY_EN
        in_parity = ^w;
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1; load_start = 1'b0; rd_addr = '0;
        drive_word(1'b0, '0, 1'b0);
        tick; tick;
        reset = 1'b0;
        repeat (5) tick;
        checks++; if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
        checks++; if (load_count !== 5'd0) $display("FAIL reset_load_count: got %0d want 0", load_count); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock); rd_addr = AW'(a); #1;
            checks++; if (rd_instr !== 3'b000) $display("FAIL reset_mem[%0d]: got %b want 000", a, rd_instr); else passed++;
        end
        tick;
    endtask

    task automatic test_full_load;
        load_start = 1'b1; tick; load_start = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL full_in_ready_load: got %b want 1", in_ready); else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            drive_word(1'b1, 3'b011, 1'b0);
            exp_q.push_back(3'b011);
            if (i == 0) begin
                rd_addr = '0; #1;
                checks++; if (rd_instr !== 3'b000) $display("FAIL full_read_old: got %b want 000", rd_instr); else passed++;
            end
            tick;
        end
        checks++; if (load_count !== 5'd16) $display("FAIL full_load_count: got %0d want 16", load_count); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready_end: got %b want 0", in_ready); else passed++;
        checks++; if (cpu_reset !== 1'b0) $display("FAIL full_run_next: got %b want 0", cpu_reset); else passed++;
        // Excess words must not be accepted.
        drive_word(1'b1, 3'b110, 1'b0);
        tick; tick;
        drive_word(1'b0, '0, 1'b0);
        checks++; if (load_count !== 5'd16) $display("FAIL full_excess_count: got %0d want 16", load_count); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL full_error: got %b want 0", error); else passed++;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock); rd_addr = AW'(a); #1; e = exp_q.pop_front();
            checks++; if (rd_instr !== e) $display("FAIL full_mem[%0d]: got %b want %b", a, rd_instr, e); else passed++;
        end
        tick;
    endtask

    task automatic test_short_load;
        logic [INSTR_W-1:0] words [3];
        int n;
        words = '{3'b011, 3'b101, 3'b111};
        load_start = 1'b1; tick; load_start = 1'b0;
        checks++; if (cpu_reset !== 1'b1) $display("FAIL short_reload_cpu_reset: got %b want 1", cpu_reset); else passed++;
        checks++; if (load_count !== 5'd0) $display("FAIL short_count_clear: got %0d want 0", load_count); else passed++;
        for (int i = 0; i < 3; i++) begin
            drive_word(1'b1, words[i], i == 2);
            exp_q.push_back(words[i]);
            if (i == 1) begin
                rd_addr = 4'd1; #1;
                checks++; if (rd_instr !== 3'b011) $display("FAIL short_read_old: got %b want 011", rd_instr); else passed++;
            end
            tick;
        end
        drive_word(1'b0, '0, 1'b0);
        checks++; if (load_count !== 5'd3) $display("FAIL short_load_count: got %0d want 3", load_count); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL short_fill_in_ready: got %b want 0", in_ready); else passed++;
        for (int a = 3; a < DEPTH; a++) exp_q.push_back(3'b000);
        n = 0;
        while (cpu_reset === 1'b1 && n < 40) begin tick; n++; end
        checks++; if (n != 13) $display("FAIL short_fill_cycles: got %0d want 13", n); else passed++;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock); rd_addr = AW'(a); #1; e = exp_q.pop_front();
            checks++; if (rd_instr !== e) $display("FAIL short_mem[%0d]: got %b want %b", a, rd_instr, e); else passed++;
        end
        tick;
    endtask

    task automatic test_valid_gating;
        logic               v_tab  [5];
        logic [INSTR_W-1:0] w_tab  [5];
        int n;
        v_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        w_tab = '{3'b001, 3'b110, 3'b010, 3'b111, 3'b100};
        // Pulse in RUN: the pointer rests at the last entry, which must stay zero.
        drive_word(1'b1, 3'b110, 1'b0); tick; drive_word(1'b0, '0, 1'b0);
        rd_addr = 4'd15; #1;
        checks++; if (rd_instr !== 3'b000) $display("FAIL gate_run_mem15: got %b want 000", rd_instr); else passed++;
        checks++; if (load_count !== 5'd3) $display("FAIL gate_run_count: got %0d want 3", load_count); else passed++;
        reset = 1'b1; tick; reset = 1'b0; tick;
        drive_word(1'b1, 3'b110, 1'b0); tick; drive_word(1'b0, '0, 1'b0);
        rd_addr = 4'd0; #1;
        checks++; if (rd_instr !== 3'b000) $display("FAIL gate_idle_mem0: got %b want 000", rd_instr); else passed++;
        checks++; if (load_count !== 5'd0) $display("FAIL gate_idle_count: got %0d want 0", load_count); else passed++;
        load_start = 1'b1; tick; load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_word(v_tab[i], w_tab[i], i == 4);
            load_start = (i == 1);
            if (v_tab[i]) exp_q.push_back(w_tab[i]);
            tick;
        end
        load_start = 1'b0;
        drive_word(1'b0, '0, 1'b0);
        checks++; if (load_count !== 5'd3) $display("FAIL gate_load_count: got %0d want 3", load_count); else passed++;
        for (int a = 3; a < DEPTH; a++) exp_q.push_back(3'b000);
        n = 0;
        while (cpu_reset === 1'b1 && n < 40) begin tick; n++; end
        checks++; if (n != 13) $display("FAIL gate_fill_cycles: got %0d want 13", n); else passed++;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock); rd_addr = AW'(a); #1; e = exp_q.pop_front();
            checks++; if (rd_instr !== e) $display("FAIL gate_mem[%0d]: got %b want %b", a, rd_instr, e); else passed++;
        end
        tick;
    endtask

    task automatic test_reset_mid_load;
        load_start = 1'b1; tick; load_start = 1'b0;
        drive_word(1'b1, 3'b101, 1'b0); tick;
        drive_word(1'b1, 3'b110, 1'b0); reset = 1'b1; tick;
        reset = 1'b0; drive_word(1'b0, '0, 1'b0);
        tick;
        checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", in_ready); else passed++;
        checks++; if (cpu_reset !== 1'b1) $display("FAIL midrst_cpu_reset: got %b want 1", cpu_reset); else passed++;
        checks++; if (load_count !== 5'd0) $display("FAIL midrst_load_count: got %0d want 0", load_count); else passed++;
        for (int a = 0; a < DEPTH; a++) exp_q.push_back(3'b000);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clock); rd_addr = AW'(a); #1; e = exp_q.pop_front();
            checks++; if (rd_instr !== e) $display("FAIL midrst_mem[%0d]: got %b want %b", a, rd_instr, e); else passed++;
        end
        tick;
    endtask

`ifdef PROGRAM_LOADER_PARITY_EN
    task automatic test_parity;
        load_start = 1'b1; tick; load_start = 1'b0;
        drive_word(1'b1, 3'b010, 1'b0); tick;
        drive_word(1'b1, 3'b011, 1'b0); in_parity = 1'b1; tick;
        drive_word(1'b0, '0, 1'b0);
        checks++; if (error !== 1'b1) $display("FAIL par_error: got %b want 1", error); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL par_in_ready: got %b want 0", in_ready); else passed++;
        checks++; if (load_count !== 5'd1) $display("FAIL par_load_count: got %0d want 1", load_count); else passed++;
        rd_addr = 4'd1; #1;
        checks++; if (rd_instr !== 3'b000) $display("FAIL par_mem1: got %b want 000", rd_instr); else passed++;
        load_start = 1'b1; tick; load_start = 1'b0; tick; tick;
        checks++; if (in_ready !== 1'b0) $display("FAIL par_stuck_in_ready: got %b want 0", in_ready); else passed++;
        checks++; if (cpu_reset !== 1'b1) $display("FAIL par_cpu_reset: got %b want 1", cpu_reset); else passed++;
        checks++; if (error !== 1'b1) $display("FAIL par_sticky: got %b want 1", error); else passed++;
        reset = 1'b1; tick; reset = 1'b0; tick;
        checks++; if (error !== 1'b0) $display("FAIL par_clear: got %b want 0", error); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_full_load;
        test_short_load;
        test_valid_gating;
        test_reset_mid_load;
`ifdef PROGRAM_LOADER_PARITY_EN
        test_parity;
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of program entries (power of two).
REQ-002 SHALL have parameter INSTR_W, default 3, instruction width in bits.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle request to begin a new program load.
REQ-006 SHALL have port in_valid  input  1  in_instr/in_last valid this cycle.
REQ-007 SHALL have port in_instr  input  INSTR_W  instruction word to store.
REQ-008 SHALL have port in_last  input  1  marks final word of the load.
REQ-009 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port rd_addr  input  log2(DEPTH)  CPU program-counter read address.
REQ-011 SHALL have port rd_instr  output  INSTR_W  program word at rd_addr.
REQ-012 SHALL have port cpu_reset  output  1  holds the CPU in reset while not running.
REQ-013 SHALL have port load_count  output  log2(DEPTH)+1  words accepted in the current/last load.
REQ-014 SHALL have port error  output  1  sticky load error (parity build only; else constant 0).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, FILL, RUN, ERR.
REQ-016 IDLE: in_ready=0, cpu_reset=1; load_start -> LOAD, write pointer and load_count cleared.
REQ-017 LOAD: in_ready=1, cpu_reset=1; word accepted when in_valid && in_ready, written to entry at write pointer, pointer and load_count +1.
REQ-018 LOAD: accepted word with in_last=1, or accepted word at pointer DEPTH-1, SHALL end loading; -> FILL if pointer < DEPTH-1, else -> RUN.
REQ-019 FILL: in_ready=0; one no-op word (all zero) written per cycle from pointer+1 through DEPTH-1, then -> RUN.
REQ-020 RUN: in_ready=0, cpu_reset=0 starting the cycle after the transition.
REQ-021 load_start in RUN SHALL -> LOAD with cpu_reset=1 the next cycle; load_start in LOAD/FILL SHALL be ignored.
REQ-022 in_valid outside LOAD SHALL be ignored; memory unchanged.
REQ-023 rd_instr SHALL be combinational from memory at rd_addr (zero-cycle read latency); a write and read to one address in the same cycle returns the old word.
REQ-024 Write pointer SHALL never wrap; excess words beyond DEPTH are never accepted.

Reset
REQ-025 Reset SHALL force IDLE, all DEPTH entries to zero, pointer=0, load_count=0, error=0, cpu_reset=1, in_ready=0.
REQ-026 Reset asserted mid-LOAD or mid-FILL SHALL abandon the load; partial contents are cleared.

Configuration
REQ-027 Macro PROGRAM_LOADER_PARITY_EN SHALL add input in_parity (1 bit, even parity over in_instr).
REQ-028 With macro: parity mismatch on an accepted word SHALL skip the write, set error, -> ERR (in_ready=0, cpu_reset=1); only reset exits ERR.
REQ-029 Without macro: no in_parity port, no ERR entry, error tied 0.

Structure
REQ-030 Shared package SHALL hold state enum, DEPTH/INSTR_W defaults, NOP word constant (all zero).
REQ-031 Storage SHALL be a sub-module program_mem (sync write, async read, sync clear).
REQ-032 FSM, pointer and counter SHALL live in program_loader.

Verification
REQ-033 Reset then idle 5 cycles -> cpu_reset=1, in_ready=0, rd_instr=0 at every address.
REQ-034 load_start; words 3'b011, 3'b101, 3'b111 (last on 3rd) -> load_count=3, FILL writes addr 3..15 as 0, RUN after 13 FILL cycles, rd_addr=1 gives 3'b101.
REQ-035 16 words 3'b011 with in_last never set -> ends at 16th, no FILL, load_count=16, in_ready=0, RUN next cycle.
REQ-036 in_valid toggled 1/0 during LOAD and pulsed in IDLE/RUN -> only LOAD-state handshakes counted and written.
REQ-037 Reset at 2nd word of a load -> IDLE, all entries 0, load_count=0.
REQ-038 With PROGRAM_LOADER_PARITY_EN: 2nd word 3'b011 with in_parity=1 -> error=1, state ERR, entry 1 unchanged, cpu_reset=1 until reset.
